instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Consumer side of the program counter: owns the fetch PC and issues instruction reads.
//  Sends word reads over a req/gnt/rvalid bus. Allows one read outstanding at a time.
//  Buffers returned words with their PCs in a small FIFO toward decode (valid/ready).
//  Branch/jump redirects flush the FIFO and discard any in-flight response.
// PARAMETERS
//  RESET_ADDR  32'h0000_0000  fetch PC loaded on reset (word aligned)
//  BUF_DEPTH   2              instruction FIFO entries (power of 2, >=2)
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_ni         in   1   reset, asynchronous, active-low
//  redirect_i     in   1   taken branch/jump: restart fetch at redirect_pc_i
//  redirect_pc_i  in   32  new fetch address; bits [1:0] ignored (forced 0)
//  mem_req_o      out  1   read request to instruction memory
//  mem_addr_o     out  32  word address of the request, bits [1:0]=0
//  mem_gnt_i      in   1   request accepted this cycle
//  mem_rvalid_i   in   1   read data valid; earliest 1 cycle after gnt
//  mem_rdata_i    in   32  read data
//  instr_valid_o  out  1   FIFO head valid
//  instr_ready_i  in   1   decode accepts head (pop when valid&ready)
//  instr_o        out  32  head instruction word
//  instr_pc_o     out  32  PC of head instruction
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert):
//  - fetch_pc=RESET_ADDR, FSM=FETCH, FIFO empty.
//  - mem_req_o=0, mem_addr_o=RESET_ADDR; instr_valid_o=0, instr_o=0, instr_pc_o=0.
//  Credit rule:
//  - mem_req_o=1 only in FETCH and when (fifo_count + outstanding) < BUF_DEPTH.
//  - FIFO can never overflow.
//  FSM:
//  - FETCH: mem_req_o as per credit; mem_addr_o=fetch_pc.
//    - On gnt: fetch_pc+=4 (wraps 32'hFFFF_FFFC->0), go to WAIT.
//  - WAIT: mem_req_o=0. On rvalid: push {rdata, pc_of_request} and go to FETCH.
//  - DRAIN: mem_req_o=0. On rvalid: discard the data and go to FETCH.
//  Bus rule: while mem_req_o=1 and not granted, mem_addr_o is held stable unless redirect_i.
//  Redirect (sampled at the edge):
//  - fetch_pc<={redirect_pc_i[31:2],2'b00}; FIFO cleared (same-cycle pop ignored).
//  - If a request is outstanding after this edge (WAIT, or gnt this cycle) -> DRAIN.
//    Otherwise -> FETCH.
//  - rvalid in the same cycle as redirect is discarded, never pushed.
//  - An ungranted request is retargeted: the next cycle's mem_addr_o is the new PC.
//  Latency:
//  - First mem_req_o=1 in the first cycle after rst_ni deasserts.
//  - rvalid at edge N -> instr_valid_o=1 with that word after edge N.
//  - Redirect at edge N -> request to new PC no earlier than cycle N+1.
//    When draining, it follows the cycle after the drained rvalid.
//  Simultaneous push+pop in the same cycle: count is unchanged and data order is preserved.
//  instr_o and instr_pc_o hold their value while instr_valid_o=1 and ready=0.
//  Throughput: one instruction per 2 cycles with 1-cycle memory (single outstanding).
// TESTING
//  1 Reset, then release with gnt=1 and 1-cycle rvalid returning PC-tagged words,
//    ready=1 -> instr_pc_o sequence 0x0,0x4,0x8,0xC; instr_o = the matching data.
//  2 ready=0 with memory always granting -> exactly BUF_DEPTH (2) words buffered.
//    mem_req_o stays 0 until a pop; PCs are in order with none lost.
//  3 redirect_i=1, redirect_pc_i=32'h0000_0032 while in WAIT.
//    -> the pending rvalid word is dropped; the next mem_addr_o is 32'h0000_0030.
//    -> the next instr_pc_o is 0x30.
//  4 redirect in the same cycle as gnt and in the same cycle as rvalid.
//    -> neither old-path word ever reaches instr_valid_o.
//  5 gnt held low 5 cycles -> mem_addr_o is stable at 0x0 across all five cycles.
//    Then redirect to 0x100 -> the next cycle's mem_addr_o is 0x100.
//  6 redirect to 32'hFFFF_FFFC, then fetch 2 words -> instr_pc_o 0xFFFF_FFFC then 0x0.
//    rst_ni pulsed mid-WAIT -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, issues single-outstanding word reads and
// buffers returned words with their PCs in a small FIFO toward decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);
  localparam int AW = $clog2(BUF_DEPTH);
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, cnt;
  logic [31:0] instr_q [BUF_DEPTH];
  logic [31:0] ipc_q [BUF_DEPTH];
  logic        req, gnt_ok, busy, push, pop;
  // Pointers carry one extra bit so full and empty are distinguishable.
  assign cnt           = wr_q - rd_q;
  assign req           = state_q == S_FETCH && cnt < (AW+1)'(BUF_DEPTH);
  assign mem_req_o     = rst_ni && req;
  assign mem_addr_o    = pc_q;
  assign gnt_ok        = req && mem_gnt_i;
  assign busy          = state_q != S_FETCH;
  assign push          = state_q == S_WAIT && mem_rvalid_i && !redirect_i;
  assign instr_valid_o = cnt != '0;
  assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
  assign instr_o       = instr_q[rd_q[AW-1:0]];
  assign instr_pc_o    = ipc_q[rd_q[AW-1:0]];
  always_comb begin
    state_d = gnt_ok ? S_WAIT : (busy && mem_rvalid_i) ? S_FETCH : state_q;
    pc_d    = gnt_ok ? pc_q + 32'd4 : pc_q;
    wr_d    = wr_q + (AW+1)'(push);
    rd_d    = rd_q + (AW+1)'(pop);
    if (redirect_i) begin
      // A response still owed after this edge must be swallowed in DRAIN.
      state_d = (gnt_ok || (busy && !mem_rvalid_i)) ? S_DRAIN : S_FETCH;
      pc_d    = redirect_pc_i & 32'hFFFF_FFFC;
      rd_d    = wr_q;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_ADDR;
      req_pc_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      if (gnt_ok) req_pc_q <= pc_q;
      if (push) begin
        instr_q[wr_q[AW-1:0]] <= mem_rdata_i;
        ipc_q[wr_q[AW-1:0]]   <= req_pc_q;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random and directed fetch traffic against a PC-stream
// reference model with a responder that returns address-derived words.
module tb_instr_fetch_unit;
  logic        clk_i = 0, rst_ni = 0, redirect_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0, instr_ready_i = 0;
  logic [31:0] redirect_pc_i = 0, mem_rdata_i = 0;
  logic        mem_req_o, instr_valid_o;
  logic [31:0] mem_addr_o, instr_o, instr_pc_o;
  int          n_checks = 0, n_fail = 0, pops = 0, max_dly = 0, dly = 0, p0 = 0;
  logic        pend = 0, chk_tgt = 0, hold_addr = 0;
  logic [31:0] pend_addr = 0, exp_pc = 0, tgt = 0, last_addr = 0;

  instr_fetch_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at the falling edge, judge the DUT, then track the bus.
  task automatic cycle(input logic redir, input logic [31:0] rpc, input logic rdy, input logic gnt);
    logic rv, req, v;
    logic [31:0] addr;
    rv = pend && dly == 0;
    redirect_i = redir; redirect_pc_i = rpc; instr_ready_i = rdy; mem_gnt_i = gnt;
    mem_rvalid_i = rv; mem_rdata_i = rv ? word_of(pend_addr) : $urandom;
    #1;
    req = mem_req_o; addr = mem_addr_o; v = instr_valid_o;
    if (pend) check("single_outstanding", {31'b0, req}, 32'd0);
    if (hold_addr && req) check("addr_stable", addr, last_addr);
    if (chk_tgt && req) begin
      check("redirect_addr", addr, tgt);
      chk_tgt = 0;
    end
    if (redir) begin
      exp_pc = rpc & ~32'd3;
      tgt = exp_pc;
      chk_tgt = 1;
    end else if (v && rdy) begin
      check("instr_pc", instr_pc_o, exp_pc);
      check("instr", instr_o, word_of(exp_pc));
      exp_pc += 4;
      pops++;
    end
    hold_addr = req && !gnt && !redir;
    last_addr = addr;
    @(posedge clk_i);
    if (rv) pend = 0;
    else if (pend && dly > 0) dly--;
    if (req && gnt) begin
      pend = 1;
      pend_addr = addr;
      dly = $urandom_range(max_dly, 0);
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 0;
    redirect_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; instr_ready_i = 0;
    #1;
    check("rst_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", instr_pc_o, 32'h0);
    repeat (2) @(negedge clk_i);
    pend = 0; dly = 0; exp_pc = 0; chk_tgt = 0; hold_addr = 0;
    rst_ni = 1;
    #1;
    check("post_rst_req", {31'b0, mem_req_o}, 32'd1);
  endtask

  initial begin
    @(negedge clk_i);
    // 1: back-to-back fetch with 1-cycle memory, one word per 2 cycles
    do_reset();
    p0 = pops;
    repeat (9) cycle(0, 0, 1, 1);
    check("t1_pops", pops - p0, 4);
    // 2: decode stalled, exactly BUF_DEPTH words buffered
    do_reset();
    repeat (10) cycle(0, 0, 0, 1);
    check("t2_req", {31'b0, mem_req_o}, 32'd0);
    check("t2_valid", {31'b0, instr_valid_o}, 32'd1);
    p0 = pops;
    repeat (2) cycle(0, 0, 1, 0);
    check("t2_pops", pops - p0, 2);
    check("t2_empty", {31'b0, instr_valid_o}, 32'd0);
    // 3: redirect while a response is pending
    do_reset();
    cycle(0, 0, 0, 1);
    dly = 2;
    cycle(1, 32'h0000_0032, 1, 0);
    p0 = pops;
    repeat (10) cycle(0, 0, 1, 1);
    check("t3_pops", {31'b0, pops > p0}, 32'd1);
    // 4a: redirect together with grant
    do_reset();
    cycle(1, 32'h0000_0200, 1, 1);
    p0 = pops;
    repeat (8) cycle(0, 0, 1, 1);
    check("t4a_pops", {31'b0, pops > p0}, 32'd1);
    // 4b: redirect together with rvalid
    do_reset();
    cycle(0, 0, 1, 1);
    cycle(1, 32'h0000_0300, 1, 0);
    p0 = pops;
    repeat (8) cycle(0, 0, 1, 1);
    check("t4b_pops", {31'b0, pops > p0}, 32'd1);
    // 5: ungranted request holds its address, then is retargeted
    do_reset();
    repeat (5) begin
      cycle(0, 0, 1, 0);
      check("t5_addr", mem_addr_o, 32'h0);
    end
    cycle(1, 32'h0000_0100, 1, 0);
    check("t5_retarget", mem_addr_o, 32'h0000_0100);
    // 6: PC wraps past the top of the address space
    do_reset();
    cycle(1, 32'hFFFF_FFFC, 1, 0);
    p0 = pops;
    repeat (6) cycle(0, 0, 1, 1);
    check("t6_pops", {31'b0, pops - p0 >= 2}, 32'd1);
    // 6b: asynchronous reset mid-WAIT with a word buffered
    do_reset();
    repeat (3) cycle(0, 0, 0, 1);
    #2;
    do_reset();
    // Random traffic with random latency, stalls and redirects
    max_dly = 2;
    p0 = pops;
    for (int i = 0; i < 3000; i++)
      cycle($urandom % 20 == 0, ($urandom % 4 == 0) ? 32'hFFFF_FFF0 | ($urandom % 16) : $urandom,
            $urandom % 10 < 6, $urandom % 10 < 7);
    check("rand_progress", {31'b0, pops - p0 > 200}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
